// File: rtl/btn_pkg.sv
// Shared state type and 50 MHz default timing for the button event classifier.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        GAP   = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } btn_state_t;

    localparam logic [23:0] BTN_LONG_DEF   = 24'd5_000_000;
    localparam logic [23:0] BTN_GAP_DEF    = 24'd2_500_000;
    localparam logic [23:0] BTN_REPEAT_DEF = 24'd1_000_000;

endpackage

// File: rtl/btn_sat_counter.sv
// Saturating up-counter with clear/enable and a terminal compare at limit-1.
module btn_sat_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced presses into short / long / double gesture pulses.
// Define BTN_AUTO_REPEAT_EN to get repeat_tick pulses while long-held.
module button_event_classifier
    import btn_pkg::*;
#(
    parameter int unsigned      CNT_W         = 24,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = CNT_W'(BTN_LONG_DEF),
    parameter logic [CNT_W-1:0] GAP_CYCLES    = CNT_W'(BTN_GAP_DEF),
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = CNT_W'(BTN_REPEAT_DEF)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn_level,
    input  logic btn_press,
    input  logic btn_release,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic busy
);

    btn_state_t       state_q, state_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q;
    logic             tick_d;
    logic             cnt_clr, cnt_en, cnt_hit;
    logic [CNT_W-1:0] cnt_lim;
    logic             press_v, rel_v;

    // Coincident strobes cancel each other out.
    assign press_v = btn_press & ~btn_release;
    assign rel_v   = btn_release & ~btn_press;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        tick_d   = 1'b0;
        cnt_en   = 1'b0;
        cnt_lim  = LONG_CYCLES;
        unique case (state_q)
            IDLE: begin
                if (press_v) state_d = HELD1;
            end
            HELD1: begin
                cnt_en = 1'b1;
                if (rel_v) begin
                    state_d = GAP;
                end else if (!btn_level) begin
                    state_d = IDLE;
                end else if (cnt_hit) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            GAP: begin
                cnt_en  = 1'b1;
                cnt_lim = GAP_CYCLES;
                if (press_v) begin
                    double_d = 1'b1;
                    state_d  = HELD2;
                end else if (cnt_hit) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HELD2: begin
                if (rel_v || !btn_level) state_d = IDLE;
            end
            LONG: begin
                cnt_lim = REPEAT_CYCLES;
                if (rel_v || !btn_level) begin
                    state_d = IDLE;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else begin
                    cnt_en = 1'b1;
                    tick_d = cnt_hit;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        cnt_clr = (state_d != state_q) || tick_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            busy_q   <= (state_d != IDLE);
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    logic tick_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign repeat_tick = tick_q;
`else
    assign repeat_tick = 1'b0;
`endif

    btn_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_lim),
        .hit   (cnt_hit)
    );

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: deadline-based reference model plus
// directed gesture scenarios and randomized debouncer-like stimulus.
module tb_button_event_classifier;

    localparam int LONG_N = 20;
    localparam int GAP_N  = 10;
    localparam int REP_N  = 5;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic btn_level = 1'b0;
    logic btn_press = 1'b0;
    logic btn_release = 1'b0;
    logic short_press, long_press, double_press, repeat_tick, busy;

    button_event_classifier #(
        .CNT_W         (8),
        .LONG_CYCLES   (8'd20),
        .GAP_CYCLES    (8'd10),
        .REPEAT_CYCLES (8'd5)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .repeat_tick  (repeat_tick),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int printed = 0;
    int cyc = 0;
    int mark = 0;

    // Reference model: gesture phase plus an absolute deadline cycle.
    localparam int PH_NONE  = 0;
    localparam int PH_DOWN1 = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_DOWN2 = 3;
    localparam int PH_HOLD  = 4;
    int ph = PH_NONE;
    int deadline = 0;
    logic e_short, e_long, e_dbl, e_tick, e_busy;

    // Pulse observations for the directed scenarios.
    int n_short, n_long, n_dbl, n_tick;
    int t_short, t_long, t_dbl;
    int t_tick [8];
    logic b_short;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                         nm, got, exp, cyc);
            end
        end
    endtask

    always @(posedge CLK) begin
        logic pv, rv;
        cyc++;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_dbl   = 1'b0;
        e_tick  = 1'b0;
        pv = btn_press && !btn_release;
        rv = btn_release && !btn_press;
        if (!RST_N) begin
            ph = PH_NONE;
        end else begin
            case (ph)
                PH_NONE: if (pv) begin
                    ph = PH_DOWN1;
                    deadline = cyc + LONG_N;
                end
                PH_DOWN1: begin
                    if (rv) begin
                        ph = PH_WAIT;
                        deadline = cyc + GAP_N;
                    end else if (!btn_level) begin
                        ph = PH_NONE;
                    end else if (cyc == deadline) begin
                        e_long = 1'b1;
                        ph = PH_HOLD;
                        deadline = cyc + REP_N;
                    end
                end
                PH_WAIT: begin
                    if (pv) begin
                        e_dbl = 1'b1;
                        ph = PH_DOWN2;
                    end else if (cyc == deadline) begin
                        e_short = 1'b1;
                        ph = PH_NONE;
                    end
                end
                PH_DOWN2: if (rv || !btn_level) ph = PH_NONE;
                default: begin
                    if (rv || !btn_level) begin
                        ph = PH_NONE;
                    end else if (cyc == deadline) begin
`ifdef BTN_AUTO_REPEAT_EN
                        e_tick = 1'b1;
`endif
                        deadline = cyc + REP_N;
                    end
                end
            endcase
        end
        e_busy = (ph != PH_NONE);
        #1;
        chk("short_press", int'(short_press), int'(e_short));
        chk("long_press", int'(long_press), int'(e_long));
        chk("double_press", int'(double_press), int'(e_dbl));
        chk("repeat_tick", int'(repeat_tick), int'(e_tick));
        chk("busy", int'(busy), int'(e_busy));
        if (short_press) begin
            n_short++;
            t_short = cyc;
            b_short = busy;
        end
        if (long_press) begin
            n_long++;
            t_long = cyc;
        end
        if (double_press) begin
            n_dbl++;
            t_dbl = cyc;
        end
        if (repeat_tick) begin
            if (n_tick < 8) t_tick[n_tick] = cyc;
            n_tick++;
        end
    end

    task automatic drv(input logic p, input logic r, input logic l);
        @(negedge CLK);
        RST_N = 1'b1;
        btn_press = p;
        btn_release = r;
        btn_level = l;
        mark = cyc;
    endtask

    task automatic press_btn();
        drv(1'b1, 1'b0, 1'b1);
    endtask

    task automatic rel_btn();
        drv(1'b0, 1'b1, 1'b0);
    endtask

    task automatic hold(input int n);
        repeat (n) drv(1'b0, 1'b0, btn_level);
    endtask

    task automatic clr_obs();
        n_short = 0;
        n_long = 0;
        n_dbl = 0;
        n_tick = 0;
        t_short = -1;
        t_long = -1;
        t_dbl = -1;
        b_short = 1'b1;
    endtask

    initial begin
        int mp, mr, mp2;
        logic p, r, l;
        int unsigned rr;
        clr_obs();

        repeat (3) @(negedge CLK);
        chk("reset short", int'(short_press), 0);
        chk("reset long", int'(long_press), 0);
        chk("reset double", int'(double_press), 0);
        chk("reset tick", int'(repeat_tick), 0);
        chk("reset busy", int'(busy), 0);
        hold(2);

        // Short press
        clr_obs();
        press_btn();
        mp = mark;
        hold(4);
        rel_btn();
        mr = mark;
        chk("short rel offset", mr - mp, 5);
        hold(16);
        chk("short count", n_short, 1);
        chk("short latency", t_short - mr, 11);
        chk("short busy at pulse", int'(b_short), 0);
        chk("short no long", n_long, 0);
        chk("short no double", n_dbl, 0);

        // Long press
        clr_obs();
        press_btn();
        mp = mark;
        hold(39);
        chk("long count", n_long, 1);
        chk("long latency", t_long - mp, 21);
`ifdef BTN_AUTO_REPEAT_EN
        chk("tick count", n_tick, 3);
        chk("tick 1", t_tick[0] - mp, 26);
        chk("tick 2", t_tick[1] - mp, 31);
        chk("tick 3", t_tick[2] - mp, 36);
`else
        chk("tick absent", n_tick, 0);
`endif
        rel_btn();
        hold(1);
        chk("long busy after release", int'(busy), 0);
        hold(12);
        chk("long no short", n_short, 0);
        chk("long single pulse", n_long, 1);
`ifdef BTN_AUTO_REPEAT_EN
        chk("tick stops on release", n_tick, 3);
`else
        chk("tick still absent", n_tick, 0);
`endif

        // Double press
        clr_obs();
        press_btn();
        hold(4);
        rel_btn();
        hold(3);
        press_btn();
        mp2 = mark;
        hold(29);
        chk("double count", n_dbl, 1);
        chk("double latency", t_dbl - mp2, 1);
        rel_btn();
        hold(3);
        chk("double no long", n_long, 0);
        chk("double no short", n_short, 0);

        // Boundary: release at count LONG-1, press at count GAP-1
        clr_obs();
        press_btn();
        mp = mark;
        hold(19);
        rel_btn();
        mr = mark;
        hold(9);
        press_btn();
        mp2 = mark;
        chk("bnd press offset", mp2 - mr, 10);
        hold(3);
        chk("bnd no long", n_long, 0);
        chk("bnd no short", n_short, 0);
        chk("bnd double", n_dbl, 1);
        chk("bnd double latency", t_dbl - mp2, 1);
        rel_btn();
        hold(3);

        // Reset mid-HELD1
        clr_obs();
        press_btn();
        hold(5);
        @(negedge CLK);
        btn_press = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rst busy async", int'(busy), 0);
        chk("rst long async", int'(long_press), 0);
        hold(30);
        rel_btn();
        hold(15);
        chk("rst no short", n_short, 0);
        chk("rst no long", n_long, 0);
        chk("rst no double", n_dbl, 0);
        chk("rst busy after", int'(busy), 0);

        // Coincident strobes from idle
        clr_obs();
        drv(1'b1, 1'b1, 1'b0);
        hold(1);
        chk("coincident busy", int'(busy), 0);
        hold(25);
        chk("coincident no pulse", n_short + n_long + n_dbl, 0);

        // Level drops in HELD1 without a release strobe
        clr_obs();
        press_btn();
        hold(3);
        drv(1'b0, 1'b0, 1'b0);
        hold(1);
        chk("lvl drop busy", int'(busy), 0);
        hold(25);
        chk("lvl drop no pulse", n_short + n_long + n_dbl, 0);

        // Randomized debouncer-like traffic, checked by the model
        for (int i = 0; i < 5000; i++) begin
            rr = $urandom_range(0, 999);
            p = 1'b0;
            r = 1'b0;
            l = btn_level;
            if (rr < 3) begin
                @(negedge CLK);
                RST_N = 1'b0;
                btn_press = 1'b0;
                btn_release = 1'b0;
                continue;
            end else if (rr < 10) begin
                p = 1'b1;
                r = 1'b1;
            end else if (rr < 15) begin
                l = ~btn_level;
            end else if (rr < 20) begin
                p = btn_level;
                r = ~btn_level;
            end else if (rr < 90) begin
                l = ~btn_level;
                p = l;
                r = ~l;
            end
            drv(p, r, l);
        end
        hold(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
